// File: rtl/sat_ctr_table_if.sv
// Lookup/update/clear bundle for the pattern-history table.
// The table side takes the slave modport; the driver takes master.
interface sat_ctr_table_if #(
    parameter int CTR_W = 2,
    parameter int IDX_W = 4
);
    logic             clear;
    logic             lookup_valid;
    logic [IDX_W-1:0] lookup_idx;
    logic             update_valid;
    logic [IDX_W-1:0] update_idx;
    logic             update_taken;
    logic             pred_valid;
    logic             pred_taken;
    logic [CTR_W-1:0] pred_ctr;
    logic             sat_hit;

    modport master (
        output clear,
        output lookup_valid,
        output lookup_idx,
        output update_valid,
        output update_idx,
        output update_taken,
        input  pred_valid,
        input  pred_taken,
        input  pred_ctr,
        input  sat_hit
    );

    modport slave (
        input  clear,
        input  lookup_valid,
        input  lookup_idx,
        input  update_valid,
        input  update_idx,
        input  update_taken,
        output pred_valid,
        output pred_taken,
        output pred_ctr,
        output sat_hit
    );
endinterface

// File: rtl/sat_ctr_table.sv
// Pattern-history table of saturating counters.
// Flop storage allows a single-cycle clear of every entry.
module sat_ctr_table #(
    parameter int CTR_W = 2,
    parameter int IDX_W = 4,
    parameter int INIT  = 0
) (
    input logic           clock,
    input logic           reset,
    sat_ctr_table_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] INIT_V  = CTR_W'(INIT);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    logic [CTR_W-1:0] r_tbl [ENTRIES];
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [CTR_W-1:0] r_pred_ctr;
    logic             r_sat_hit;

    logic [CTR_W-1:0] w_cur;
    logic [CTR_W-1:0] w_next;
    logic [CTR_W-1:0] w_rd;
    logic             w_sat;
    logic             w_upd;
    logic             w_byp;

    always_comb begin
        w_cur  = r_tbl[bus.update_idx];
        w_sat  = bus.update_taken ? (w_cur == CTR_MAX)
                                  : (w_cur == '0);
        w_next = w_cur;
        if (!w_sat) begin
            w_next = bus.update_taken ? w_cur + CTR_W'(1)
                                      : w_cur - CTR_W'(1);
        end
        w_upd = bus.update_valid & ~bus.clear & ~w_sat;
        // Same-index lookup sees the value this edge will write
        w_byp = bus.update_valid
              && (bus.lookup_idx == bus.update_idx);
        if (bus.clear)
            w_rd = INIT_V;
        else if (w_byp)
            w_rd = w_next;
        else
            w_rd = r_tbl[bus.lookup_idx];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++)
                r_tbl[i] <= INIT_V;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_ctr   <= '0;
            r_sat_hit    <= 1'b0;
        end else begin
            if (bus.clear) begin
                for (int i = 0; i < ENTRIES; i++)
                    r_tbl[i] <= INIT_V;
            end else if (w_upd) begin
                r_tbl[bus.update_idx] <= w_next;
            end
            r_sat_hit    <= bus.update_valid & ~bus.clear & w_sat;
            r_pred_valid <= bus.lookup_valid;
            if (bus.lookup_valid) begin
                r_pred_ctr   <= w_rd;
                r_pred_taken <= w_rd[CTR_W-1];
            end
        end
    end

    assign bus.pred_valid = r_pred_valid;
    assign bus.pred_taken = r_pred_taken;
    assign bus.pred_ctr   = r_pred_ctr;
    assign bus.sat_hit    = r_sat_hit;
endmodule

// File: tb/tb_sat_ctr_table.sv
// Bench for sat_ctr_table: 2b/16 and 3b/64 instances against
// an array model of the counter rules.
module tb_sat_ctr_table;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    sat_ctr_table_if #(.CTR_W(2), .IDX_W(4)) ba ();
    sat_ctr_table_if #(.CTR_W(3), .IDX_W(6)) bb ();

    sat_ctr_table #(.CTR_W(2), .IDX_W(4), .INIT(0)) u_a (
        .clock (clock),
        .reset (rst_n),
        .bus   (ba)
    );

    sat_ctr_table #(.CTR_W(3), .IDX_W(6), .INIT(3)) u_b (
        .clock (clock),
        .reset (rst_n),
        .bus   (bb)
    );

    int total = 0;
    int bad   = 0;
    int ma [16];
    int mb [64];
    int ea  = 0;
    int eb  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nxt(input int v, input int t, input int mx);
        if (t != 0) return (v < mx) ? v + 1 : v;
        return (v > 0) ? v - 1 : 0;
    endfunction

    task automatic idle_a();
        ba.clear        = 1'b0;
        ba.lookup_valid = 1'b0;
        ba.lookup_idx   = 'x;
        ba.update_valid = 1'b0;
        ba.update_idx   = 'x;
        ba.update_taken = 1'bx;
    endtask

    task automatic idle_b();
        bb.clear        = 1'b0;
        bb.lookup_valid = 1'b0;
        bb.lookup_idx   = 'x;
        bb.update_valid = 1'b0;
        bb.update_idx   = 'x;
        bb.update_taken = 1'bx;
    endtask

    task automatic reset_models();
        foreach (ma[i]) ma[i] = 0;
        foreach (mb[i]) mb[i] = 3;
        ea = 0;
        eb = 0;
    endtask

    task automatic step_a(input int lv, input int li, input int uv,
                          input int ui, input int ut, input int clr,
                          input string tag);
        int sat;
        sat = 0;
        ba.clear        = (clr != 0);
        ba.lookup_valid = (lv != 0);
        ba.lookup_idx   = 4'(li);
        ba.update_valid = (uv != 0);
        ba.update_idx   = 4'(ui);
        ba.update_taken = (ut != 0);
        if (clr != 0) begin
            foreach (ma[i]) ma[i] = 0;
        end else if (uv != 0) begin
            sat = (ut != 0) ? int'(ma[ui] == 3) : int'(ma[ui] == 0);
            ma[ui] = nxt(ma[ui], ut, 3);
        end
        if (lv != 0) ea = ma[li];
        @(posedge clock);
        #1;
        chk({tag, ".pv"}, ba.pred_valid, (lv != 0));
        chk({tag, ".ctr"}, ba.pred_ctr, ea);
        chk({tag, ".tk"}, ba.pred_taken, (ea >= 2));
        chk({tag, ".sat"}, ba.sat_hit, sat);
        idle_a();
    endtask

    task automatic step_b(input int lv, input int li, input int uv,
                          input int ui, input int ut, input int clr,
                          input string tag);
        int sat;
        sat = 0;
        bb.clear        = (clr != 0);
        bb.lookup_valid = (lv != 0);
        bb.lookup_idx   = 6'(li);
        bb.update_valid = (uv != 0);
        bb.update_idx   = 6'(ui);
        bb.update_taken = (ut != 0);
        if (clr != 0) begin
            foreach (mb[i]) mb[i] = 3;
        end else if (uv != 0) begin
            sat = (ut != 0) ? int'(mb[ui] == 7) : int'(mb[ui] == 0);
            mb[ui] = nxt(mb[ui], ut, 7);
        end
        if (lv != 0) eb = mb[li];
        @(posedge clock);
        #1;
        chk({tag, ".pv"}, bb.pred_valid, (lv != 0));
        chk({tag, ".ctr"}, bb.pred_ctr, eb);
        chk({tag, ".tk"}, bb.pred_taken, (eb >= 4));
        chk({tag, ".sat"}, bb.sat_hit, sat);
        idle_b();
    endtask

    initial begin
        idle_a();
        idle_b();
        reset_models();
        #2;
        chk("rst.a.pv", ba.pred_valid, 0);
        chk("rst.a.ctr", ba.pred_ctr, 0);
        chk("rst.a.sat", ba.sat_hit, 0);
        chk("rst.b.pv", bb.pred_valid, 0);
        chk("rst.b.ctr", bb.pred_ctr, 0);
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            step_a(1, i, 0, 0, 0, 0, "init");
        step_a(0, 0, 0, 0, 0, 0, "idle");

        for (int k = 0; k < 5; k++)
            step_a(1, 3, 1, 3, 1, 0, "sat.up");
        for (int k = 0; k < 5; k++)
            step_a(1, 3, 1, 3, 0, 0, "sat.dn");
        step_a(1, 3, 0, 0, 0, 0, "sat.rd");

        step_a(0, 0, 1, 7, 1, 0, "byp.set7");
        step_a(0, 0, 1, 8, 1, 0, "byp.set8");
        step_a(0, 0, 1, 8, 1, 0, "byp.set8");
        step_a(0, 0, 1, 8, 1, 0, "byp.set8");
        step_a(1, 7, 1, 7, 1, 0, "byp.same");
        step_a(1, 8, 1, 7, 1, 0, "byp.diff");
        step_a(1, 7, 0, 0, 0, 0, "byp.rd7");

        for (int k = 0; k < 3; k++) begin
            step_a(0, 0, 1, 2, 1, 0, "clr.ld");
            step_a(0, 0, 1, 5, 1, 0, "clr.ld");
            step_a(0, 0, 1, 9, 1, 0, "clr.ld");
        end
        step_a(1, 9, 0, 0, 0, 0, "clr.pre");
        step_a(1, 2, 1, 2, 1, 1, "clr.hit");
        for (int i = 0; i < 16; i++)
            step_a(1, i, 0, 0, 0, 0, "clr.post");

        for (int k = 0; k < 10; k++) begin
            step_b(0, 0, 1, 63, 1, 0, "w.up");
            step_b(1, 63, 0, 0, 0, 0, "w.lk63");
        end
        step_b(1, 62, 0, 0, 0, 0, "w.lk62");

        for (int k = 0; k < 300; k++)
            step_a($urandom_range(0, 1), $urandom_range(0, 15),
                   $urandom_range(0, 1), $urandom_range(0, 15),
                   $urandom_range(0, 1),
                   int'($urandom_range(0, 31) == 0), "rnd.a");
        for (int k = 0; k < 200; k++)
            step_b($urandom_range(0, 1), $urandom_range(60, 63),
                   $urandom_range(0, 1), $urandom_range(60, 63),
                   $urandom_range(0, 1),
                   int'($urandom_range(0, 63) == 0), "rnd.b");

        for (int i = 0; i < 16; i++)
            step_a(0, 0, 1, i, 1, 0, "ar.ld");
        step_a(1, 4, 0, 0, 0, 0, "ar.lk");
        step_a(1, 5, 0, 0, 0, 0, "ar.lk");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.pv", ba.pred_valid, 0);
        chk("ar.ctr", ba.pred_ctr, 0);
        chk("ar.tk", ba.pred_taken, 0);
        chk("ar.b.pv", bb.pred_valid, 0);
        reset_models();
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++)
            step_a(1, i, 0, 0, 0, 0, "ar.post");
        step_b(1, 63, 0, 0, 0, 0, "ar.b63");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
